// File: rtl/fetch_if.sv
// Fetch unit bus bundle: core redirect, instruction-memory req/ack and core-side valid/ready.
// master = fetch unit side, slave = memory/core environment side.
interface fetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory reads, DEPTH-entry prefetch FIFO, redirect flush.
// Optional macro FETCH_BYPASS_EN: ack data goes straight to the core when the FIFO is empty.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_mem_addr;
  logic          r_mem_req;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_inst_valid;
  logic [31:0]   r_inst;
  logic [31:0]   r_inst_pc;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];

  state_t        w_state_nxt;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   w_mem_addr_nxt;
  logic [31:0]   w_redirect_pc;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_after_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic          w_head_valid;
  logic [31:0]   w_head_data;
  logic [31:0]   w_head_pc;
`ifdef FETCH_BYPASS_EN
  logic          w_bypass;
`endif

  assign w_redirect_pc   = bus.redirect_pc & ~32'h3;
  assign w_pop           = r_inst_valid & bus.inst_ready;
  assign w_cnt_after_pop = r_count - CW'(w_pop);
  assign w_rd_ptr_nxt    = r_rd_ptr + AW'(w_pop);

  // Next-state, next fetch PC, push decision and next request address
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    w_cnt_nxt      = w_cnt_after_pop;
`ifdef FETCH_BYPASS_EN
    w_bypass       = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = S_REQ;
        end else if (w_cnt_after_pop < FULL) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = bus.mem_ack ? S_REQ : S_DROP;
        end else if (bus.mem_ack) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
`ifdef FETCH_BYPASS_EN
          w_bypass = (r_count == '0);
          w_push   = ~(w_bypass & bus.inst_ready);
`else
          w_push   = 1'b1;
`endif
          w_cnt_nxt   = w_cnt_after_pop + CW'(w_push);
          w_state_nxt = (w_cnt_nxt < FULL) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = bus.mem_ack ? S_REQ : S_DROP;
        end else if (bus.mem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.redirect) begin
      w_cnt_nxt = '0;
    end
    // An outstanding request keeps its address until acknowledged, even across a redirect
    if ((r_state != S_IDLE) && !bus.mem_ack) begin
      w_mem_addr_nxt = r_mem_addr;
    end else begin
      w_mem_addr_nxt = w_fetch_pc_nxt;
    end
  end

  // Head of the FIFO as it will look next cycle, so core outputs come straight from flops
  always_comb begin
    w_head_valid = 1'b0;
    w_head_data  = '0;
    w_head_pc    = '0;
    if (!bus.redirect) begin
      if (w_cnt_after_pop == '0) begin
        if (w_push) begin
          w_head_valid = 1'b1;
          w_head_data  = bus.mem_rdata;
          w_head_pc    = r_fetch_pc;
        end
      end else begin
        w_head_valid = 1'b1;
        w_head_data  = r_fifo_data[w_rd_ptr_nxt];
        w_head_pc    = r_fifo_pc[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_mem_addr   <= RESET_PC;
      r_mem_req    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_req    <= (w_state_nxt != S_IDLE);
      r_count      <= w_cnt_nxt;
      r_inst_valid <= w_head_valid;
      r_inst       <= w_head_data;
      r_inst_pc    <= w_head_pc;
      if (bus.redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + AW'(w_push);
        r_rd_ptr <= w_rd_ptr_nxt;
      end
    end
  end

  // Storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
      r_fifo_data[r_wr_ptr] <= bus.mem_rdata;
    end
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
`ifdef FETCH_BYPASS_EN
  assign bus.inst_valid = r_inst_valid | w_bypass;
  assign bus.inst       = w_bypass ? bus.mem_rdata : r_inst;
  assign bus.inst_pc    = w_bypass ? r_fetch_pc : r_inst_pc;
`else
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
`endif

endmodule
